// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear sequencer states.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // x0 is hard-wired to zero and never holds a pending producer.
  localparam int ZERO_REG = 0;

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: x0 check, same-cycle writeback bypass and
// pending lookup. Outputs are forced to zero until the clear sequence ends.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                       ready,
  input  logic                       we,
  input  logic [AW-1:0]              wa,
  input  logic [XLEN-1:0]            wd,
  input  logic [AW-1:0]              ra,
  input  logic [NREG-1:0][XLEN-1:0]  rf,
  input  logic [NREG-1:0]            pend,
  output logic [XLEN-1:0]            rd,
  output logic                       rpend
);

  // Select zero, bypassed write data, or stored data plus pending flag.
  always_comb begin
    rd    = '0;
    rpend = 1'b0;
    if (ready && (ra != AW'(ZERO_REG))) begin
      if (we && (wa == ra)) begin
        // The writeback in flight clears pending, so the bypass reports 0.
        rd = wd;
      end else begin
        rd    = rf[ra];
        rpend = pend[ra];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// pending scoreboard and a sequenced synchronous clear after reset.
//
// Interface timing: there is no valid/ready handshake here. we/wa/wd and
// pset/paddr are single-cycle qualifiers sampled on the rising edge; reads are
// combinational. state_dbg exposes the clear FSM for checkers.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rpend,
  input  logic                pset,
  input  logic [AW-1:0]       paddr,
  output logic                init_busy,
  output state_e              state_dbg
);

  state_e                    state;
  // One extra bit so the terminal count never aliases with zero.
  logic [AW:0]               cnt;
  logic [NREG-1:0][XLEN-1:0] rf;
  logic [NREG-1:0]           pend;
  logic                      ready;

  assign ready     = (state == READY);
  assign state_dbg = state;

  // Clear FSM, storage and scoreboard updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          rf[cnt[AW-1:0]]   <= '0;
          pend[cnt[AW-1:0]] <= 1'b0;
          cnt               <= cnt + (AW+1)'(1);
          if (cnt == (AW+1)'(NREG-1)) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          if (we && (wa != AW'(ZERO_REG))) begin
            rf[wa]   <= wd;
            pend[wa] <= 1'b0;
          end
          // Placed after the write so a new producer to the same register wins.
          if (pset && (paddr != AW'(ZERO_REG))) begin
            pend[paddr] <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // One read port per slice of the packed ra/rd/rpend buses.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rdport (
      .ready (ready),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .ra    (ra[port_lsb(i, AW) +: AW]),
      .rf    (rf),
      .pend  (pend),
      .rd    (rd[port_lsb(i, XLEN) +: XLEN]),
      .rpend (rpend[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = $clog2(NREG);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic                we = 1'b0;
  logic [AW-1:0]       wa = '0;
  logic [XLEN-1:0]     wd = '0;
  logic [NRD*AW-1:0]   ra = '0;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rpend;
  logic                pset = 1'b0;
  logic [AW-1:0]       paddr = '0;
  logic                init_busy;
  state_e              state_dbg;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .rpend     (rpend),
    .pset      (pset),
    .paddr     (paddr),
    .init_busy (init_busy),
    .state_dbg (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_rf [NREG];
  bit              m_pend [NREG];
  int              clear_left = 0;
  bit              m_valid = 1'b0;

  // Reset wipes everything; the register file then stays invisible for NREG
  // cycles, so the zeroing can be modelled as instantaneous.
  always @(posedge clk) begin
    if (reset) begin
      m_valid    = 1'b1;
      clear_left = NREG;
      for (int r = 0; r < NREG; r++) begin
        m_rf[r]   = '0;
        m_pend[r] = 1'b0;
      end
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (we && wa != 0) begin
        m_rf[wa]   = wd;
        m_pend[wa] = 1'b0;
      end
      if (pset && paddr != 0) m_pend[paddr] = 1'b1;
    end
  end

  // Compare every port against the model each cycle, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {63'd0, init_busy}, {63'd0, clear_left > 0});
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] e_rd;
        logic            e_pd;
        a    = ra[p*AW +: AW];
        e_rd = '0;
        e_pd = 1'b0;
        if (clear_left == 0 && a != 0) begin
          if (we && wa == a) e_rd = wd;
          else begin
            e_rd = m_rf[a];
            e_pd = m_pend[a];
          end
        end
        check($sformatf("model_rd%0d", p), {32'd0, rd[p*XLEN +: XLEN]}, {32'd0, e_rd});
        check($sformatf("model_rpend%0d", p), {63'd0, rpend[p]}, {63'd0, e_pd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int port, input int addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    ra[port*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rd_of(input int port);
    return rd[port*XLEN +: XLEN];
  endfunction

  // Counts negedges with init_busy high, bounded; optionally drops we after 20.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!init_busy) break;
      n++;
      if (n == 20) we = 1'b0;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    // 1. clear sequence
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!init_busy) break;
      n++;
      if (rd !== '0 || rpend !== '0) check("clear_reads_zero", {rd, rpend}, '0);
    end
    check("clear_len", 64'(n), 64'd32);
    tick();
    for (int r = 1; r < NREG; r += 2) begin
      set_ra(0, r);
      set_ra(1, (r + 1) % NREG);
      @(negedge clk);
      check("post_clear_rd0", {32'd0, rd_of(0)}, 64'd0);
      check("post_clear_rd1", {32'd0, rd_of(1)}, 64'd0);
      tick();
    end

    // 2. write then read on both ports
    we = 1'b1; wa = 5; wd = 32'h0000DCBA;
    tick();
    we = 1'b0; set_ra(0, 5); set_ra(1, 5);
    @(negedge clk);
    check("wr_rd0", {32'd0, rd_of(0)}, 64'h0000DCBA);
    check("wr_rd1", {32'd0, rd_of(1)}, 64'h0000DCBA);
    check("wr_rpend", {62'd0, rpend}, 64'd0);
    tick();

    // 3. same-cycle bypass
    we = 1'b1; wa = 9; wd = 32'h10000000; set_ra(0, 9);
    @(negedge clk);
    check("bypass_rd0", {32'd0, rd_of(0)}, 64'h10000000);
    tick();
    we = 1'b0;

    // 4. x0 protection
    we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; pset = 1'b1; paddr = 0; set_ra(0, 0);
    @(negedge clk);
    check("x0_rd_during", {32'd0, rd_of(0)}, 64'd0);
    check("x0_rpend_during", {63'd0, rpend[0]}, 64'd0);
    tick();
    we = 1'b0; pset = 1'b0;
    @(negedge clk);
    check("x0_rd_after", {32'd0, rd_of(0)}, 64'd0);
    check("x0_rpend_after", {63'd0, rpend[0]}, 64'd0);
    tick();

    // 5. scoreboard
    pset = 1'b1; paddr = 6;
    tick();
    pset = 1'b0; set_ra(1, 6);
    @(negedge clk);
    check("pend_set", {63'd0, rpend[1]}, 64'd1);
    tick();
    we = 1'b1; wa = 6; wd = 32'h10; pset = 1'b1; paddr = 6;
    @(negedge clk);
    check("pend_bypass_rd1", {32'd0, rd_of(1)}, 64'h10);
    check("pend_bypass_rpend1", {63'd0, rpend[1]}, 64'd0);
    tick();
    we = 1'b0; pset = 1'b0;
    @(negedge clk);
    check("pend_new_producer", {63'd0, rpend[1]}, 64'd1);
    check("pend_data_kept", {32'd0, rd_of(1)}, 64'h10);
    tick();

    // 6. reset mid-clear; rf[4] first made nonzero
    we = 1'b1; wa = 4; wd = 32'hCAFE0004;
    tick();
    we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1; we = 1'b1; wa = 4; wd = 32'hDEADBEEF;
    tick();
    reset = 1'b0;
    count_busy(n);
    check("reclear_len", 64'(n), 64'd32);
    we = 1'b0;
    tick();
    set_ra(0, 4); set_ra(1, 4);
    @(negedge clk);
    check("reclear_rf4", {32'd0, rd_of(0)}, 64'd0);
    tick();

    // Randomized traffic; ra often aimed at wa/paddr to exercise bypass.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      we    = $urandom_range(0, 1);
      wa    = AW'($urandom_range(0, NREG - 1));
      wd    = $urandom;
      pset  = ($urandom_range(0, 3) == 0);
      paddr = AW'($urandom_range(0, NREG - 1));
      for (int p = 0; p < NRD; p++) begin
        case ($urandom_range(0, 3))
          0: set_ra(p, int'(wa));
          1: set_ra(p, int'(paddr));
          default: set_ra(p, $urandom_range(0, NREG - 1));
        endcase
      end
      tick();
    end
    reset = 1'b0; we = 1'b0; pset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core integer register file, for the pipelined RISC-V core.
- Adds a configurable number of read ports and write-to-read bypass, so no half-cycle negedge write is needed.
- Adds a sequenced synchronous clear and a per-register pending scoreboard for hazard detection.
- Sits between the decode stage (reads, pending set) and the writeback stage (write).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
AW, $clog2(NREG), address width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
we  in  1  write enable (writeback stage)
wa  in  AW  write address
wd  in  XLEN  write data
ra  in  NRD*AW  packed read addresses, port i at bits [i*AW +: AW]
rd  out  NRD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN]
rpend  out  NRD  per-port pending flag for the register addressed by ra[i]
pset  in  1  mark a destination register pending (decode issues a producer)
paddr  in  AW  register to mark pending
init_busy  out  1  high while the clear sequence runs

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high (`reset`).
- States: CLEAR and READY.
- Reset behaviour:
  - `reset` forces state CLEAR and clear counter cnt=0 on the next edge.
  - A reset asserted mid-clear restarts at cnt=0.
- CLEAR state:
  - Each cycle writes 0 to rf[cnt], clears pend[cnt], then cnt++.
  - When cnt==NREG-1 the state goes to READY on the following edge. CLEAR lasts exactly NREG cycles after reset deasserts.
  - init_busy=1 in CLEAR, 0 in READY.
  - we and pset are ignored.
  - rd=0 and rpend=0 on all ports.
- Reset values: init_busy=1; rd=0; rpend=0. All are held while reset is high and throughout CLEAR.
- READY write: on a rising edge with we=1 and wa!=0, rf[wa]<=wd and pend[wa]<=0. A write to x0 is dropped.
- READY pending set: on a rising edge with pset=1 and paddr!=0, pend[paddr]<=1. pset to x0 is ignored.
- Simultaneous we and pset to the same address: data is written and pend ends at 1 (the new producer wins).
- Read path (combinational, zero latency), for each port i:
  - ra[i]==0: rd_i=0, rpend_i=0.
  - else if we && wa==ra[i]: rd_i=wd and rpend_i=0 (bypass; the same-cycle writeback is visible).
  - else: rd_i=rf[ra[i]] and rpend_i=pend[ra[i]].
- Bypass and pset interaction: if pset targets ra[i] in the same cycle, rpend_i still reflects the pre-edge state. pset takes effect next cycle.
- Multiple ports reading the same address return identical values.
- No arithmetic other than the cnt increment. cnt is AW+1 bits wide to avoid wrap ambiguity when NREG=2^AW.
- No initial blocks. All state comes from the reset/clear sequence.

Decomposition:
- Package `regfile_pkg`:
  - state enum {CLEAR, READY}.
  - Localparam helpers for packed port slicing.
  - Constant ZERO_REG=0.
- One natural sub-module: `regfile_rdport` (one instance per read port via generate). It contains the x0 check, the bypass compare and the pend lookup.
- Storage, scoreboard and clear FSM stay in the top module.

Test Plan:
1. Clear sequence:
   - Stimulus: reset high 3 cycles, then low.
   - Response: init_busy high for exactly 32 cycles after deassert; all reads return 0 during that time; then init_busy=0 and rf[1..31] read 0.
2. Write then read:
   - Stimulus: we=1, wa=5, wd=0x0000DCBA; next cycle ra0=5, ra1=5.
   - Response: both ports read 0x0000DCBA, rpend=0.
3. Same-cycle bypass:
   - Stimulus: we=1, wa=9, wd=0x10000000, ra0=9 in the same cycle.
   - Response: rd0=0x10000000 combinationally, before the edge.
4. x0 protection:
   - Stimulus: we=1, wa=0, wd=0xFFFFFFFF; pset=1, paddr=0.
   - Response: ra0=0 reads 0, rpend0=0, both during the write cycle and after it.
5. Scoreboard:
   - Stimulus: pset paddr=6; next cycle ra1=6.
   - Response: rpend1=1.
   - Stimulus: later we wa=6, wd=0x10 in the same cycle as pset paddr=6.
   - Response: rd1=0x10 bypassed, rpend1=0 that cycle, rpend1=1 the next cycle.
6. Reset mid-clear:
   - Stimulus: reset at clear cycle 10, deasserted after 1 cycle; we=1 wa=4 driven during CLEAR.
   - Response: init_busy high for 32 cycles after the second deassert; rf[4] reads 0 afterwards.
